// File: rtl/fft_pkg.sv
// Shared constants, bank-state encoding and bit-reversal helper for the
// FFT output reorder block and its ping-pong RAM.
package fft_pkg;

    // Default geometry: 16-bit real/imag words, 64-point frames.
    localparam int FFT_DW    = 16;
    localparam int FFT_N     = 64;
    localparam int FFT_LOG2N = 6;

    // Life cycle of one ping-pong bank.
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    // Reverse the low 'bits' bits of v; bits above 'bits' come back as zero.
    function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < bits) begin
                r = (r << 1) | ((v >> i) & 32'd1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_ram.sv
// Ping-pong frame store: two banks of N complex words. Each bank takes two
// writes per cycle (one per FFT lane) and offers one registered read port.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int N  = FFT_N,
    parameter int AW = FFT_LOG2N
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic            wbank_i,
    input  logic [AW-1:0]   waddr0_i,
    input  logic [AW-1:0]   waddr1_i,
    input  logic [2*DW-1:0] wdata0_i,
    input  logic [2*DW-1:0] wdata1_i,
    input  logic            re_i,
    input  logic            rbank_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [2*DW-1:0] rdata_o
);

    logic [2*DW-1:0] bank0_mem [N];
    logic [2*DW-1:0] bank1_mem [N];
    logic [2*DW-1:0] rdata_q;

    // Bank 0 write port: both lanes of a pair land in the same bank.
    always_ff @(posedge clk_i) begin
        if (we_i && !wbank_i) begin
            bank0_mem[waddr0_i] <= wdata0_i;
            bank0_mem[waddr1_i] <= wdata1_i;
        end
    end

    // Bank 1 write port.
    always_ff @(posedge clk_i) begin
        if (we_i && wbank_i) begin
            bank1_mem[waddr0_i] <= wdata0_i;
            bank1_mem[waddr1_i] <= wdata1_i;
        end
    end

    // Registered read; the word holds while re_i is low so a stalled
    // pipeline keeps its fetched sample.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= rbank_i ? bank1_mem[raddr_i] : bank0_mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_out_reorder.sv
// Collects the two-lane output of the in-place FFT into ping-pong banks and
// replays each frame as a serial natural-order stream with valid/ready.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int DW        = FFT_DW,
    parameter int N         = FFT_N,
    parameter int BITREV_IN = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic [DW-1:0]        inReal0,
    input  logic [DW-1:0]        inImag0,
    input  logic [DW-1:0]        inReal1,
    input  logic [DW-1:0]        inImag1,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        outReal,
    output logic [DW-1:0]        outImag,
    output logic [$clog2(N)-1:0] out_index,
    output logic                 out_last,
    output logic                 frame_err
);

    localparam int LOG2N = $clog2(N);
    localparam int PW    = LOG2N - 1;   // pair counter width (N/2 pairs)

    // Control state
    bank_state_e      bank_q [2];
    bank_state_e      bank_d [2];
    logic             wptr_q, wptr_d;     // bank being written
    logic             rd_bank_q, rd_bank_d; // bank being fetched from RAM
    logic             rptr_q, rptr_d;     // bank whose samples are on the output
    logic [PW-1:0]    wcnt_q, wcnt_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic             frame_err_q;
    logic             err_set;

    // Read pipeline: fetch stage flag plus registered output sample
    logic             p1_vld_q;
    logic [LOG2N-1:0] p1_idx_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [DW-1:0]    out_real_q;
    logic [DW-1:0]    out_imag_q;
    logic [LOG2N-1:0] out_index_q;

    // Datapath wiring
    bank_state_e      wstate;
    logic             wr_acc;
    logic             we;
    logic [PW-1:0]    pair;
    logic [PW-1:0]    pair_rev;
    logic [LOG2N-1:0] waddr0, waddr1;
    logic             out_adv;
    logic             rd_avail;
    logic             rd_issue;
    logic             drain_done;
    logic [2*DW-1:0]  rdata;

    assign wstate   = bank_q[wptr_q];
    assign in_ready = (wstate == EMPTY) || (wstate == FILLING);
    assign wr_acc   = in_valid && in_ready;

    // A beat carrying in_first always restarts at pair 0.
    assign pair     = in_first ? '0 : wcnt_q;
    assign pair_rev = PW'(bitrev(32'(pair), PW));
    assign waddr0   = (BITREV_IN != 0) ? {1'b0, pair_rev} : {pair, 1'b0};
    assign waddr1   = (BITREV_IN != 0) ? {1'b1, pair_rev} : {pair, 1'b1};

    // The output register can take a new sample when empty or being accepted.
    assign out_adv    = !out_valid_q || out_ready;
    // Starting a bank needs it FULL; mid-bank fetches continue unconditionally.
    assign rd_avail   = (rcnt_q == '0) ? (bank_q[rd_bank_q] == FULL) : 1'b1;
    assign rd_issue   = rd_avail && (!p1_vld_q || out_adv);
    assign drain_done = out_valid_q && out_ready && out_last_q;

    // Next-state for bank FSMs, pointers and counters. Write, fetch-start and
    // release always act on banks in different states, so they never collide.
    always_comb begin
        bank_d    = bank_q;
        wptr_d    = wptr_q;
        wcnt_d    = wcnt_q;
        rd_bank_d = rd_bank_q;
        rcnt_d    = rcnt_q;
        rptr_d    = rptr_q;
        err_set   = 1'b0;
        we        = 1'b0;

        if (wr_acc) begin
            if (in_first) begin
                // A restart during FILLING abandons the partial frame.
                err_set        = (wstate == FILLING);
                bank_d[wptr_q] = FILLING;
                we             = 1'b1;
                wcnt_d         = PW'(1);
            end else if (wstate == EMPTY) begin
                // Mid-frame data with no frame start: dropped.
                err_set = 1'b1;
            end else begin
                we = 1'b1;
                if (wcnt_q == PW'(N/2 - 1)) begin
                    bank_d[wptr_q] = FULL;
                    wcnt_d         = '0;
                    wptr_d         = !wptr_q;
                end else begin
                    wcnt_d = wcnt_q + PW'(1);
                end
            end
        end

        if (rd_issue) begin
            if (rcnt_q == '0) begin
                bank_d[rd_bank_q] = DRAINING;
            end
            if (rcnt_q == LOG2N'(N - 1)) begin
                rcnt_d    = '0;
                rd_bank_d = !rd_bank_q;
            end else begin
                rcnt_d = rcnt_q + LOG2N'(1);
            end
        end

        if (drain_done) begin
            bank_d[rptr_q] = EMPTY;
            rptr_d         = !rptr_q;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bank_q[0]   <= EMPTY;
            bank_q[1]   <= EMPTY;
            wptr_q      <= 1'b0;
            rd_bank_q   <= 1'b0;
            rptr_q      <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            wptr_q      <= wptr_d;
            rd_bank_q   <= rd_bank_d;
            rptr_q      <= rptr_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            frame_err_q <= frame_err_q | err_set;
        end
    end

    // Fetch stage: tracks the bin whose word is sitting in the RAM read register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            p1_vld_q <= 1'b0;
            p1_idx_q <= '0;
        end else if (rd_issue) begin
            p1_vld_q <= 1'b1;
            p1_idx_q <= rcnt_q;
        end else if (out_adv) begin
            p1_vld_q <= 1'b0;
        end
    end

    // Output stage: loads the fetched word, holds everything while stalled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            out_index_q <= '0;
        end else if (out_adv) begin
            out_valid_q <= p1_vld_q;
            if (p1_vld_q) begin
                out_real_q  <= rdata[2*DW-1:DW];
                out_imag_q  <= rdata[DW-1:0];
                out_index_q <= p1_idx_q;
                out_last_q  <= (p1_idx_q == LOG2N'(N - 1));
            end
        end
    end

    fft_pingpong_ram #(
        .DW (DW),
        .N  (N),
        .AW (LOG2N)
    ) u_ram (
        .clk_i    (clk),
        .we_i     (we),
        .wbank_i  (wptr_q),
        .waddr0_i (waddr0),
        .waddr1_i (waddr1),
        .wdata0_i ({inReal0, inImag0}),
        .wdata1_i ({inReal1, inImag1}),
        .re_i     (rd_issue),
        .rbank_i  (rd_bank_q),
        .raddr_i  (rcnt_q),
        .rdata_o  (rdata)
    );

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign outReal   = out_real_q;
    assign outImag   = out_imag_q;
    assign out_index = out_index_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: frames are described in natural bin order, the
// bench scatters them onto the two FFT lanes and expects them back in order.
module tb_fft_out_reorder;

    localparam int DW   = 16;
    localparam int N    = 64;
    localparam int HALF = N / 2;
    localparam int PB   = 5;   // bits of a pair number

    typedef struct {
        logic        v;
        logic        r;
        logic        last;
        logic [5:0]  idx;
        logic [15:0] re;
        logic [15:0] im;
        int          cyc;
    } smp_t;

    typedef struct {
        logic [5:0]  idx;
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } exp_t;

    logic          clk;
    logic          nrst;
    logic          in_valid, in_first;
    logic [DW-1:0] inReal0, inImag0, inReal1, inImag1;
    logic          in_ready;
    logic          out_valid, out_ready;
    logic [DW-1:0] outReal, outImag;
    logic [5:0]    out_index;
    logic          out_last;
    logic          frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_wr_cyc = 0;

    logic [15:0] fre [2][N];
    logic [15:0] fim [2][N];
    smp_t trace_q [$];
    smp_t acc_q [$];
    exp_t exp_q [$];

    fft_out_reorder #(.DW(DW), .N(N), .BITREV_IN(1)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .inReal0   (inReal0),
        .inImag0   (inImag0),
        .inReal1   (inReal1),
        .inImag1   (inImag1),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outReal   (outReal),
        .outImag   (outImag),
        .out_index (out_index),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // Plain arithmetic bit reversal of a pair number.
    function automatic int brev(input int v, input int bits);
        int r = 0;
        int x = v;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic gen_random(input int s);
        for (int b = 0; b < N; b++) begin
            fre[s][b] = 16'($urandom);
            fim[s][b] = 16'($urandom);
        end
    endtask

    task automatic gen_ramp(input int s);
        for (int b = 0; b < N; b++) begin
            fre[s][b] = 16'(b);
            fim[s][b] = 16'($urandom);
        end
    endtask

    task automatic gen_tone(input int s);
        for (int b = 0; b < N; b++) begin
            fre[s][b] = (b == 1 || b == N - 1) ? 16'h4000 : 16'h0000;
            fim[s][b] = 16'h0000;
        end
    endtask

    // Expected serial stream for one frame: every bin, in order.
    task automatic add_exp(input int s);
        for (int b = 0; b < N; b++) begin
            exp_q.push_back('{6'(b), fre[s][b], fim[s][b], (b == N - 1)});
        end
    endtask

    // Drive pairs k0..k1 of frame s; pair k carries bins brev(k) and brev(k)+N/2.
    task automatic drive_pairs(input int s, input int k0, input int k1, input bit chk_rdy);
        int b0;
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            b0 = brev(k, PB);
            in_valid = 1'b1;
            in_first = (k == 0);
            inReal0  = fre[s][b0];
            inImag0  = fim[s][b0];
            inReal1  = fre[s][b0 + HALF];
            inImag1  = fim[s][b0 + HALF];
            if (chk_rdy) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL beat_dropped pair %0d: in_ready=%b, required 1", k, in_ready);
                end
            end
            last_wr_cyc = cyc + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'b0;
        end
    endtask

    // Record every cycle and the accepted samples. mode 0: ready high,
    // 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic collect(input int nsamp, input int mode, input int budget);
        int acc = 0;
        trace_q.delete();
        acc_q.delete();
        for (int c = 0; c < budget && acc < nsamp; c++) begin
            @(negedge clk);
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = (c % 4 == 0) || (c % 4 == 3);
            else                out_ready = 1'($urandom_range(1, 0));
            trace_q.push_back('{out_valid, out_ready, out_last, out_index, outReal, outImag, cyc});
            if (out_valid && out_ready) begin
                acc_q.push_back(trace_q[trace_q.size() - 1]);
                acc++;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
        inReal0 = '0; inImag0 = '0; inReal1 = '0; inImag1 = '0;
        repeat (3) @(negedge clk);
        for (int ph = 0; ph < 2; ph++) begin
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready ph%0d: got %b, required 1", ph, in_ready); end
            vectors++;
            if (out_valid !== 1'b0 || out_last !== 1'b0) begin
                miscompares++; $display("FAIL reset_out_flags ph%0d: valid=%b last=%b, required 0 0", ph, out_valid, out_last);
            end
            vectors++;
            if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err ph%0d: got %b, required 0", ph, frame_err); end
            vectors++;
            if (outReal !== 16'h0 || outImag !== 16'h0 || out_index !== 6'd0) begin
                miscompares++; $display("FAIL reset_out_data ph%0d: re=%h im=%h idx=%0d, required 0 0 0", ph, outReal, outImag, out_index);
            end
            nrst = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_ramp();
        int first_v = -1;
        gen_ramp(0);
        exp_q.delete();
        add_exp(0);
        fork
            begin drive_pairs(0, 0, HALF - 1, 1'b1); idle(1); end
            collect(N, 0, 200);
        join
        foreach (trace_q[i]) if (first_v < 0 && trace_q[i].v) first_v = trace_q[i].cyc;
        vectors++;
        if (first_v !== last_wr_cyc + 2) begin
            miscompares++; $display("FAIL ramp_latency: first out_valid at cycle %0d, required %0d", first_v, last_wr_cyc + 2);
        end
        vectors++;
        if (acc_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL ramp_count: %0d samples, required %0d", acc_q.size(), exp_q.size());
        end
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (acc_q[i].idx !== exp_q[i].idx || acc_q[i].re !== exp_q[i].re ||
                acc_q[i].im !== exp_q[i].im || acc_q[i].last !== exp_q[i].last) begin
                miscompares++;
                $display("FAIL ramp_sample %0d: idx=%0d re=%h im=%h last=%b, required idx=%0d re=%h im=%h last=%b",
                         i, acc_q[i].idx, acc_q[i].re, acc_q[i].im, acc_q[i].last,
                         exp_q[i].idx, exp_q[i].re, exp_q[i].im, exp_q[i].last);
            end
        end
    endtask

    task automatic test_tone();
        gen_tone(1);
        exp_q.delete();
        add_exp(1);
        fork
            begin drive_pairs(1, 0, HALF - 1, 1'b1); idle(1); end
            collect(N, 0, 200);
        join
        vectors++;
        if (acc_q.size() !== N) begin
            miscompares++; $display("FAIL tone_count: %0d samples, required %0d", acc_q.size(), N);
        end
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (acc_q[i].idx !== exp_q[i].idx || acc_q[i].re !== exp_q[i].re || acc_q[i].im !== exp_q[i].im) begin
                miscompares++;
                $display("FAIL tone_bin %0d: idx=%0d re=%h im=%h, required idx=%0d re=%h im=%h",
                         i, acc_q[i].idx, acc_q[i].re, acc_q[i].im, exp_q[i].idx, exp_q[i].re, exp_q[i].im);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fa = -1;
        int la = -1;
        gen_random(0);
        gen_random(1);
        exp_q.delete();
        add_exp(0);
        add_exp(1);
        fork
            begin
                drive_pairs(0, 0, HALF - 1, 1'b1);
                idle(HALF);
                drive_pairs(1, 0, HALF - 1, 1'b1);
                idle(1);
            end
            collect(2 * N, 0, 400);
        join
        foreach (trace_q[i]) begin
            if (trace_q[i].v && trace_q[i].r) begin
                if (fa < 0) fa = i;
                la = i;
            end
        end
        vectors++;
        if (la - fa + 1 !== 2 * N || acc_q.size() !== 2 * N) begin
            miscompares++;
            $display("FAIL b2b_contiguous: span %0d cycles with %0d samples, required %0d and %0d", la - fa + 1, acc_q.size(), 2 * N, 2 * N);
        end
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (acc_q[i].idx !== exp_q[i].idx || acc_q[i].re !== exp_q[i].re ||
                acc_q[i].im !== exp_q[i].im || acc_q[i].last !== exp_q[i].last) begin
                miscompares++;
                $display("FAIL b2b_sample %0d: idx=%0d re=%h im=%h last=%b, required idx=%0d re=%h im=%h last=%b",
                         i, acc_q[i].idx, acc_q[i].re, acc_q[i].im, acc_q[i].last,
                         exp_q[i].idx, exp_q[i].re, exp_q[i].im, exp_q[i].last);
            end
        end
    endtask

    task automatic test_backpressure();
        gen_random(0);
        gen_random(1);
        exp_q.delete();
        add_exp(0);
        add_exp(1);
        fork
            begin
                drive_pairs(0, 0, HALF - 1, 1'b1);
                drive_pairs(1, 0, HALF - 1, 1'b1);
                idle(1);
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++; $display("FAIL bp_in_ready_full: in_ready=%b with both banks occupied, required 0", in_ready);
                end
            end
            collect(2 * N, 1, 1000);
        join
        for (int i = 0; i + 1 < trace_q.size(); i++) begin
            if (trace_q[i].v && !trace_q[i].r) begin
                vectors++;
                if (trace_q[i + 1].v !== 1'b1 || trace_q[i + 1].idx !== trace_q[i].idx ||
                    trace_q[i + 1].re !== trace_q[i].re || trace_q[i + 1].im !== trace_q[i].im ||
                    trace_q[i + 1].last !== trace_q[i].last) begin
                    miscompares++;
                    $display("FAIL bp_hold cycle %0d: idx=%0d re=%h then v=%b idx=%0d re=%h, required held",
                             trace_q[i].cyc, trace_q[i].idx, trace_q[i].re, trace_q[i + 1].v, trace_q[i + 1].idx, trace_q[i + 1].re);
                end
            end
        end
        vectors++;
        if (acc_q.size() !== 2 * N) begin
            miscompares++; $display("FAIL bp_count: %0d samples, required %0d", acc_q.size(), 2 * N);
        end
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (acc_q[i].idx !== exp_q[i].idx || acc_q[i].re !== exp_q[i].re ||
                acc_q[i].im !== exp_q[i].im || acc_q[i].last !== exp_q[i].last) begin
                miscompares++;
                $display("FAIL bp_sample %0d: idx=%0d re=%h im=%h last=%b, required idx=%0d re=%h im=%h last=%b",
                         i, acc_q[i].idx, acc_q[i].re, acc_q[i].im, acc_q[i].last,
                         exp_q[i].idx, exp_q[i].re, exp_q[i].im, exp_q[i].last);
            end
        end
    endtask

    task automatic test_restart();
        gen_random(0);
        gen_random(1);
        exp_q.delete();
        add_exp(1);
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++; $display("FAIL restart_err_before: frame_err=%b, required 0", frame_err);
        end
        fork
            begin
                drive_pairs(0, 0, 9, 1'b1);
                drive_pairs(1, 0, HALF - 1, 1'b1);
                idle(1);
            end
            collect(N, 0, 300);
        join
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++; $display("FAIL restart_err_after: frame_err=%b, required 1", frame_err);
        end
        vectors++;
        if (acc_q.size() !== N) begin
            miscompares++; $display("FAIL restart_count: %0d samples, required %0d", acc_q.size(), N);
        end
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (acc_q[i].idx !== exp_q[i].idx || acc_q[i].re !== exp_q[i].re ||
                acc_q[i].im !== exp_q[i].im || acc_q[i].last !== exp_q[i].last) begin
                miscompares++;
                $display("FAIL restart_sample %0d: idx=%0d re=%h im=%h last=%b, required idx=%0d re=%h im=%h last=%b",
                         i, acc_q[i].idx, acc_q[i].re, acc_q[i].im, acc_q[i].last,
                         exp_q[i].idx, exp_q[i].re, exp_q[i].im, exp_q[i].last);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        gen_random(0);
        fork
            begin drive_pairs(0, 0, HALF - 1, 1'b1); idle(1); end
            collect(20, 0, 200);
        join
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_index !== 6'd20) begin
            miscompares++; $display("FAIL mid_pre_reset: valid=%b idx=%0d, required 1 20", out_valid, out_index);
        end
        nrst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 6'd0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_async_reset: valid=%b in_ready=%b idx=%0d err=%b, required 0 1 0 0", out_valid, in_ready, out_index, frame_err);
        end
        @(negedge clk);
        nrst = 1'b1;
        out_ready = 1'b1;
        gen_random(1);
        exp_q.delete();
        add_exp(1);
        fork
            begin drive_pairs(1, 0, HALF - 1, 1'b1); idle(1); end
            collect(N, 0, 300);
        join
        vectors++;
        if (acc_q.size() !== N || frame_err !== 1'b0) begin
            miscompares++; $display("FAIL mid_next_frame: %0d samples err=%b, required %0d 0", acc_q.size(), frame_err, N);
        end
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (acc_q[i].idx !== exp_q[i].idx || acc_q[i].re !== exp_q[i].re || acc_q[i].im !== exp_q[i].im) begin
                miscompares++;
                $display("FAIL mid_sample %0d: idx=%0d re=%h im=%h, required idx=%0d re=%h im=%h",
                         i, acc_q[i].idx, acc_q[i].re, acc_q[i].im, exp_q[i].idx, exp_q[i].re, exp_q[i].im);
            end
        end
    endtask

    task automatic test_random_ready();
        for (int f = 0; f < 3; f++) begin
            gen_random(f % 2);
            exp_q.delete();
            add_exp(f % 2);
            fork
                begin drive_pairs(f % 2, 0, HALF - 1, 1'b1); idle(1); end
                collect(N, 2, 800);
            join
            vectors++;
            if (acc_q.size() !== N) begin
                miscompares++; $display("FAIL rnd_count frame %0d: %0d samples, required %0d", f, acc_q.size(), N);
            end
            for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
                vectors++;
                if (acc_q[i].idx !== exp_q[i].idx || acc_q[i].re !== exp_q[i].re ||
                    acc_q[i].im !== exp_q[i].im || acc_q[i].last !== exp_q[i].last) begin
                    miscompares++;
                    $display("FAIL rnd_sample f%0d %0d: idx=%0d re=%h im=%h last=%b, required idx=%0d re=%h im=%h last=%b",
                             f, i, acc_q[i].idx, acc_q[i].re, acc_q[i].im, acc_q[i].last,
                             exp_q[i].idx, exp_q[i].re, exp_q[i].im, exp_q[i].last);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_tone();
        test_back_to_back();
        test_backpressure();
        test_random_ready();
        test_restart();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
